// File: rtl/serial_compare_pkg.sv
// Shared types and helpers for the bit-serial compare sequencer.
package serial_compare_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    if (w <= 1) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_cmp_msb_core.sv
// MSB-first bit-serial magnitude comparator; remembers whether the prefix so far is equal/greater.
module serial_cmp_msb_core (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic lt,
  output logic eq,
  output logic gt
);

  logic prev_eq_q, prev_eq_d;
  logic prev_gt_q, prev_gt_d;

  always_comb begin
    eq = prev_eq_q & (a ~^ b);
    gt = prev_gt_q | (prev_eq_q & a & ~b);
    lt = ~eq & ~gt;
  end

  always_comb begin
    prev_eq_d = prev_eq_q;
    prev_gt_d = prev_gt_q;
    if (clear) begin
      prev_eq_d = 1'b1;
      prev_gt_d = 1'b0;
    end else if (en) begin
      prev_eq_d = eq;
      prev_gt_d = gt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_eq_q <= 1'b1;
      prev_gt_q <= 1'b0;
    end else begin
      prev_eq_q <= prev_eq_d;
      prev_gt_q <= prev_gt_d;
    end
  end

endmodule

// File: rtl/serial_compare_sequencer.sv
// Accepts parallel operand pairs, streams them MSB-first through the serial core,
// and returns a registered less/equal/greater result over a valid/ready handshake.
module serial_compare_sequencer
  import serial_compare_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1,
  parameter int unsigned SIGNED     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_less,
  output logic             out_eq,
  output logic             out_greater,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] sha_q, shb_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             less_q, eq_q, greater_q;

  logic core_clear_c, core_en_c, bit_a_c, bit_b_c, flip_c, last_c;
  logic core_lt_c, core_eq_c, core_gt_c;

  // First presented bit is inverted on both operands so signed order maps to unsigned order.
  always_comb begin
    core_clear_c = (state_q == IDLE) && in_valid && in_ready_q;
    core_en_c    = (state_q == SHIFT);
    flip_c       = (SIGNED != 0) && (cnt_q == '0);
    bit_a_c      = sha_q[WIDTH-1] ^ flip_c;
    bit_b_c      = shb_q[WIDTH-1] ^ flip_c;
    last_c       = (cnt_q == CW'(WIDTH - 1)) || ((EARLY_EXIT != 0) && !core_eq_c);
  end

  serial_cmp_msb_core u_core (
    .clk   (clk),
    .rst   (rst),
    .clear (core_clear_c),
    .en    (core_en_c),
    .a     (bit_a_c),
    .b     (bit_b_c),
    .lt    (core_lt_c),
    .eq    (core_eq_c),
    .gt    (core_gt_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sha_q       <= '0;
      shb_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      less_q      <= 1'b0;
      eq_q        <= 1'b0;
      greater_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            sha_q      <= in_a;
            shb_q      <= in_b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          sha_q <= sha_q << 1;
          shb_q <= shb_q << 1;
          cnt_q <= cnt_q + CW'(1);
          if (last_c) begin
            less_q      <= core_lt_c;
            eq_q        <= core_eq_c;
            greater_q   <= core_gt_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // A new in_valid here is not consumed; in_ready only rises back in IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_less    = less_q;
  assign out_eq      = eq_q;
  assign out_greater = greater_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Bench for serial_compare_sequencer: four configurations share stimulus, a queue holds expected results.
module tb_serial_compare_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_a, in_b;
  logic       out_ready;
  logic [3:0] iv, ir, ov, ol, oe, og, bz;

  int vectors = 0;
  int errors  = 0;
  int cyc_cnt = 0;
  int last_acc = 0;

  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // 0: W8 early-exit unsigned, 1: W8 full-length unsigned, 2: W8 early-exit signed, 3: W1
  serial_compare_sequencer #(.WIDTH(8), .EARLY_EXIT(1), .SIGNED(0)) u_ee (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[0]), .out_ready(out_ready), .out_less(ol[0]), .out_eq(oe[0]),
    .out_greater(og[0]), .busy(bz[0]));
  serial_compare_sequencer #(.WIDTH(8), .EARLY_EXIT(0), .SIGNED(0)) u_full (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[1]), .out_ready(out_ready), .out_less(ol[1]), .out_eq(oe[1]),
    .out_greater(og[1]), .busy(bz[1]));
  serial_compare_sequencer #(.WIDTH(8), .EARLY_EXIT(1), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[2]), .out_ready(out_ready), .out_less(ol[2]), .out_eq(oe[2]),
    .out_greater(og[2]), .busy(bz[2]));
  serial_compare_sequencer #(.WIDTH(1), .EARLY_EXIT(1), .SIGNED(0)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(ov[3]), .out_ready(out_ready), .out_less(ol[3]), .out_eq(oe[3]),
    .out_greater(og[3]), .busy(bz[3]));

  // Reference ordering as {less, eq, greater}.
  function automatic logic [2:0] model_flags(input logic [7:0] a, input logic [7:0] b, input int sel);
    int sa, sb;
    if (sel == 3) begin
      sa = int'(a[0]);
      sb = int'(b[0]);
    end else if (sel == 2) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    if (sa < sb) return 3'b100;
    if (sa == sb) return 3'b010;
    return 3'b001;
  endfunction

  // Cycles from accept to first out_valid: shift count plus one.
  function automatic int model_lat(input logic [7:0] a, input logic [7:0] b, input int sel);
    int w, k;
    w = (sel == 3) ? 1 : 8;
    k = w;
    if (sel != 1) begin
      for (int i = w - 1; i >= 0; i--) begin
        if (a[i] != b[i]) begin
          k = w - i;
          break;
        end
      end
    end
    return k + 1;
  endfunction

  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input bit overlap);
    exp_t e, got;
    int cyc;
    logic [2:0] obs;
    cyc = 0;
    @(negedge clk);
    while (!ir[sel] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (ir[sel] !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait sel=%0d in_ready=%b expected 1", sel, ir[sel]);
      return;
    end
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    iv[sel]   = 1'b1;
    last_acc  = cyc_cnt;
    e.flags   = model_flags(a, b, sel);
    e.lat     = model_lat(a, b, sel);
    sb_q.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      iv[sel] = 1'b0;
      cyc++;
    end while (!ov[sel] && cyc < 40);
    got = sb_q.pop_front();
    vectors++;
    if (ov[sel] !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout sel=%0d a=%h b=%h out_valid=%b expected 1", sel, a, b, ov[sel]);
      out_ready = 1'b1;
      return;
    end
    obs = {ol[sel], oe[sel], og[sel]};
    vectors++;
    if (obs !== got.flags) begin
      errors++;
      $display("FAIL flags sel=%0d a=%h b=%h got lt/eq/gt=%b expected %b", sel, a, b, obs, got.flags);
    end
    vectors++;
    if (cyc !== got.lat) begin
      errors++;
      $display("FAIL latency sel=%0d a=%h b=%h got %0d expected %0d", sel, a, b, cyc, got.lat);
    end
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        iv[sel] = (h % 2 == 0);
        in_a    = 8'($urandom);
        in_b    = 8'($urandom);
        @(negedge clk);
        obs = {ol[sel], oe[sel], og[sel]};
        vectors++;
        if ({ov[sel], ir[sel], obs} !== {2'b10, got.flags}) begin
          errors++;
          $display("FAIL hold sel=%0d cyc=%0d got valid/ready/flags=%b%b%b expected 10%b",
                   sel, h, ov[sel], ir[sel], obs, got.flags);
        end
      end
      iv[sel]   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({ov[sel], ir[sel], bz[sel]} !== 3'b010) begin
        errors++;
        $display("FAIL release sel=%0d got valid/ready/busy=%b%b%b expected 010",
                 sel, ov[sel], ir[sel], bz[sel]);
      end
    end else if (overlap) begin
      iv[sel] = 1'b1;
      @(negedge clk);
      iv[sel] = 1'b0;
      vectors++;
      if ({ov[sel], ir[sel], bz[sel]} !== 3'b010) begin
        errors++;
        $display("FAIL overlap sel=%0d got valid/ready/busy=%b%b%b expected 010",
                 sel, ov[sel], ir[sel], bz[sel]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if ({ov[s], ir[s], ol[s], oe[s], og[s], bz[s]} !== 6'b010000) begin
        errors++;
        $display("FAIL reset sel=%0d got v/r/lt/eq/gt/busy=%b%b%b%b%b%b expected 010000",
                 s, ov[s], ir[s], ol[s], oe[s], og[s], bz[s]);
      end
    end
  endtask

  task automatic test_unsigned();
    run_op(0, 8'h5A, 8'h5A, 0, 1'b0);
    run_op(1, 8'h5A, 8'h5A, 0, 1'b0);
    run_op(0, 8'h10, 8'h11, 0, 1'b0);
    run_op(0, 8'hFF, 8'h00, 0, 1'b0);
  endtask

  task automatic test_early_exit();
    run_op(0, 8'h80, 8'h7F, 0, 1'b0);
    run_op(1, 8'h80, 8'h7F, 0, 1'b0);
    run_op(1, 8'h00, 8'h01, 0, 1'b0);
  endtask

  task automatic test_signed();
    run_op(2, 8'h80, 8'h7F, 0, 1'b0);
    run_op(2, 8'hFF, 8'hFE, 0, 1'b0);
    run_op(2, 8'h00, 8'hFF, 0, 1'b0);
    run_op(2, 8'hC3, 8'hC3, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = (i % 5 == 0) ? a : 8'($urandom);
      run_op(i % 3, a, b, 0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    run_op(0, 8'h33, 8'h35, 5, 1'b0);
    run_op(2, 8'h90, 8'h10, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    in_a  = 8'h12;
    in_b  = 8'h12;
    iv[0] = 1'b1;
    cyc   = 0;
    repeat (3) begin
      @(negedge clk);
      iv[0] = 1'b0;
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({ov[0], ir[0], ol[0], oe[0], og[0], bz[0]} !== 6'b010000) begin
      errors++;
      $display("FAIL mid_reset got v/r/lt/eq/gt/busy=%b%b%b%b%b%b expected 010000 after %0d shifts",
               ov[0], ir[0], ol[0], oe[0], og[0], bz[0], cyc);
    end
    run_op(0, 8'h01, 8'h02, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    run_op(3, 8'h00, 8'h01, 0, 1'b0);
    t0 = last_acc;
    run_op(3, 8'h01, 8'h01, 0, 1'b0);
    t1 = last_acc;
    run_op(3, 8'h01, 8'h00, 0, 1'b0);
    t2 = last_acc;
    vectors++;
    if ((t1 - t0) !== 3 || (t2 - t1) !== 3) begin
      errors++;
      $display("FAIL issue_interval got %0d,%0d expected 3,3", t1 - t0, t2 - t1);
    end
    run_op(3, 8'h00, 8'h00, 0, 1'b1);
    run_op(0, 8'h44, 8'h40, 0, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    iv        = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    test_reset();
    test_unsigned();
    test_early_exit();
    test_signed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_compare_sequencer.md
Name: serial_compare_sequencer

Overview:
- Accepts a pair of parallel WIDTH-bit operands over a valid/ready handshake.
- Shifts both operands MSB-first, one bit per cycle, through a single bit-serial comparator core.
- Returns a registered less/equal/greater result over a second valid/ready handshake.
- Sits between parallel producers and the bit-serial compare datapath, and owns sequencing, core clearing, early termination and signed handling.

Parameters:
- WIDTH, 8: operand width in bits, >= 1.
- EARLY_EXIT, 1: 1 = stop shifting at the first differing bit; 0 = always shift WIDTH bits.
- SIGNED, 0: 1 = operands are two's complement; 0 = unsigned.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_less  output  1  A < B.
- out_eq  output  1  A == B.
- out_greater  output  1  A > B.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- FSM states IDLE, SHIFT, DONE, encoded as a package enum.
- Reset: state=IDLE; in_ready=1; out_valid=0; out_less=0; out_eq=0; out_greater=0; busy=0; shift registers and count=0; core cleared (eq state=1, gt state=0).
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load in_a/in_b into shift registers, count=0, pulse core clear, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle presents shreg_a[WIDTH-1] and shreg_b[WIDTH-1] to the core with en=1, shifts both registers left, count++.
  - SIGNED=1: the bit presented at count==0 is inverted on both operands (offset-binary trick); all other bits pass unchanged.
  - Exit when count==WIDTH-1, or when EARLY_EXIT=1 and the core's combinational eq output is 0.
  - On exit: register the core's combinational lt/eq/gt into out_less/out_eq/out_greater, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; outputs held stable until out_valid && out_ready.
  - On that handshake: out_valid=0, go to IDLE. Result flags retain their last values and are meaningful only while out_valid=1.
- Latency:
  - Accept edge = cycle 0. Shift cycles are 1..k, where k=WIDTH, or with EARLY_EXIT the index of the first differing bit counted from the MSB (1-based).
  - out_valid is high from cycle k+1.
  - Minimum issue interval is k+2 cycles; there is no overlap between operations.
- Exactly one of out_less/out_eq/out_greater is 1 whenever out_valid=1.
- in_valid during SHIFT/DONE is ignored, and the operand is not consumed (in_ready=0).
- WIDTH=1: SHIFT lasts exactly one cycle; the count compare is against 0.
- rst asserted in any state: the next state is IDLE with all reset values; any in-flight operation and result are discarded.
- Simultaneous out_ready and a new in_valid in DONE: only the result handshake completes; the new operand is accepted the next cycle in IDLE.

Decomposition:
- Package serial_compare_pkg:
  - state enum type.
  - function computing the count width, $clog2 of WIDTH with a minimum of 1.
- Sub-module serial_cmp_msb_core:
  - Ports: clk, rst, clear, en, a, b; outputs lt, eq, gt.
  - Registered prev_eq/prev_gt; clear/rst set prev_eq=1, prev_gt=0; state updates only when en=1.
  - eq = prev_eq & (a==b); gt = prev_gt | (prev_eq & a & ~b); lt = ~eq & ~gt.

Test Plan:
- WIDTH=8, unsigned, EARLY_EXIT=1; a=0x5A, b=0x5A -> eq=1, out_valid first high at cycle 9 after accept.
- EARLY_EXIT=1; a=0x80, b=0x7F -> greater=1, out_valid at cycle 2. With EARLY_EXIT=0, same result at cycle 9.
- SIGNED=1; a=0x80 (-128), b=0x7F -> less=1. a=0xFF, b=0xFE -> greater=1. a=0x00, b=0xFF -> greater=1.
- Backpressure: out_ready low for 5 cycles after out_valid -> flags and out_valid stable, in_ready=0; in_valid pulses in that window are not accepted. out_ready=1 -> IDLE next cycle.
- rst pulsed at the 3rd SHIFT cycle -> next cycle out_valid=0, in_ready=1, all flags 0. New op a=0x01, b=0x02 -> less=1.
- WIDTH=1: (0,1) -> less; (1,1) -> eq; (1,0) -> greater. Each out_valid at cycle 2. Back-to-back issue every 3 cycles with out_ready tied high.
